chime_sequencer: RTL
====================

Name: chime_sequencer

Overview:
Parametrised beep-train generator for the clock's hourly chime and alarm sounders. A start pulse latches a beep count. The block then plays that many tone bursts, separated by silent gaps, on the buzzer pin. A continuous mode repeats bursts until stopped, for the alarm. The block sits between the timekeeping and alarm-compare logic and the buzzer output pin.

Parameters:
COUNT_W, 5, width of beep-count input and beeps_left output
ON_CYC, 50_000_000, clk cycles per tone burst (>=1)
OFF_CYC, 50_000_000, clk cycles of silence between bursts (>=1)
TONE_HALF, 25_000, clk cycles per half-period of the tone square wave (>=1)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous active-low reset
start  input  1  one-cycle request; sampled only in IDLE
mode  input  1  0 = counted chime, 1 = continuous alarm; latched with start
count  input  COUNT_W  number of bursts for counted mode; latched with start
stop  input  1  level; aborts any sequence
buzz_out  output  1  gated tone to buzzer
beep_active  output  1  high during every burst cycle
busy  output  1  high in ON or OFF state
done  output  1  one-cycle pulse on normal completion of counted mode
beeps_left  output  COUNT_W  bursts remaining, including the current one; 0 in continuous mode

Behaviour:
- Reset (rst==0 at an edge): state IDLE. buzz_out, beep_active, busy, done = 0. beeps_left = 0. All counters = 0. Reset mid-sequence aborts on that edge. No done pulse.
- States: IDLE, ON, OFF. beep_active = (state==ON). busy = (state!=IDLE).
- IDLE + start + !stop, counted mode, count>0: latch count and mode. Enter ON on the next edge. First burst cycle is t+1 when start is sampled at t.
- IDLE + start, counted mode, count==0: stay IDLE. done=1 at t+1. No burst.
- IDLE + start, mode=1: enter ON. beeps_left=0.
- ON lasts exactly ON_CYC cycles, then:
  - counted mode, beeps_left>1: decrement beeps_left and enter OFF.
  - counted mode, beeps_left==1: set beeps_left=0, enter IDLE, done=1 for that first IDLE cycle.
  - continuous mode: always enter OFF.
- OFF lasts exactly OFF_CYC cycles, then ON. There is no trailing gap after the final burst.
- stop==1 in any state: IDLE on the next edge. buzz_out=0 from that cycle. beeps_left=0. No done.
- stop and start both high in IDLE: stop wins; start is ignored.
- start while busy: ignored. count and mode changes while busy: ignored.
- Tone:
  - The phase counter restarts on entry to ON, with tone=1 for the first TONE_HALF cycles.
  - The tone toggles every TONE_HALF cycles.
  - buzz_out = beep_active & tone, registered in step with beep_active, with no extra latency.
- Cycle counters are sized $clog2(max(ON_CYC,OFF_CYC)+1) and never wrap past the terminal value.
- done is never high together with busy.

Decomposition:
- Shared package chime_pkg:
  - state encoding localparams S_IDLE, S_ON, S_OFF
  - MODE_COUNT=0, MODE_CONT=1
- One natural sub-module, tone_gen:
  - parameter TONE_HALF
  - inputs clk, rst, restart, en
  - output tone
  - restart forces phase=high and clears the divider.
- The top level holds the FSM, the burst and gap counter, and beeps_left.

Test Plan:
All scenarios use ON_CYC=4, OFF_CYC=3, TONE_HALF=1, COUNT_W=5.
- Counted chime: start at t, count=3, mode=0 -> beep_active high t+1..t+4, t+8..t+11, t+15..t+18. busy high t+1..t+18. done=1 only at t+19. beeps_left 3,2,1,0 decrementing at t+5, t+12, t+19.
- Tone gating: same run -> buzz_out high at t+1, t+3, t+8, t+10, t+15, t+17. buzz_out low at all other cycles.
- Zero count: start, count=0 -> busy stays 0. done=1 at t+1. buzz_out never high.
- Continuous plus stop: start, mode=1 -> bursts repeat with period 7 for 30 cycles. stop asserted mid-burst at s -> busy=0 and buzz_out=0 at s+1, with no done pulse.
- Ignored inputs: during counted count=2, pulse start with count=9 at a cycle in OFF -> exactly 2 bursts, one done pulse.
- Reset mid-burst: rst=0 for one cycle during the second burst -> all outputs 0 on the next edge. A new start afterwards runs normally from a full count.

Source files
------------

// File: rtl/chime_pkg.sv
// Shared state encoding and mode constants for the chime sequencer and its tone generator.
package chime_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_t;

  localparam logic MODE_COUNT = 1'b0;
  localparam logic MODE_CONT  = 1'b1;

endpackage

// File: rtl/tone_gen.sv
// Square-wave tone source: toggles every TONE_HALF enabled cycles, restart forces the high phase.
module tone_gen #(
  parameter int TONE_HALF = 25_000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic en,
  output logic tone
);

  localparam int DW = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(TONE_HALF - 1);

  logic [DW-1:0] div;

  always_ff @(posedge clk) begin
    if (!rst) begin
      div  <= '0;
      tone <= 1'b0;
    end else if (restart) begin
      div  <= '0;
      tone <= 1'b1;
    end else if (en) begin
      if (div == DIV_LAST) begin
        div  <= '0;
        tone <= ~tone;
      end else begin
        div <= div + DW'(1);
      end
    end
  end

endmodule

// File: rtl/chime_sequencer.sv
// Beep-train generator: counted chime or continuous alarm bursts separated by silent gaps.
module chime_sequencer
  import chime_pkg::*;
#(
  parameter int COUNT_W   = 5,
  parameter int ON_CYC    = 50_000_000,
  parameter int OFF_CYC   = 50_000_000,
  parameter int TONE_HALF = 25_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,
  input  logic [COUNT_W-1:0] count,
  input  logic               stop,
  output logic               buzz_out,
  output logic               beep_active,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] beeps_left
);

  localparam int MAX_CYC = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] ON_LAST  = CW'(ON_CYC - 1);
  localparam logic [CW-1:0] OFF_LAST = CW'(OFF_CYC - 1);

  state_t             state, state_nx;
  logic [CW-1:0]      cyc;
  logic               mode_q;
  logic               done_nx;
  logic               load;
  logic               cyc_end;
  logic               restart;
  logic               tone;

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // stop overrides every transition, including a start seen in IDLE
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    done_nx  = 1'b0;
    cyc_end  = ((state == S_ON) && (cyc == ON_LAST)) ||
               ((state == S_OFF) && (cyc == OFF_LAST));
    if (stop) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (mode == MODE_CONT || count != '0) begin
              state_nx = S_ON;
              load     = 1'b1;
            end else begin
              done_nx = 1'b1;
            end
          end
        end
        S_ON: begin
          if (cyc_end) begin
            if (mode_q == MODE_CONT || beeps_left > COUNT_W'(1)) begin
              state_nx = S_OFF;
            end else begin
              state_nx = S_IDLE;
              done_nx  = 1'b1;
            end
          end
        end
        S_OFF: begin
          if (cyc_end) state_nx = S_ON;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cyc        <= '0;
      mode_q     <= MODE_COUNT;
      beeps_left <= '0;
      done       <= 1'b0;
    end else begin
      done <= done_nx;
      // cycle counter restarts on every state change and parks at its terminal value
      if (state_nx != state || state == S_IDLE) cyc <= '0;
      else if (!cyc_end)                         cyc <= cyc + CW'(1);

      if (stop) begin
        beeps_left <= '0;
      end else if (load) begin
        mode_q     <= mode;
        beeps_left <= (mode == MODE_CONT) ? '0 : count;
      end else if (state == S_ON && cyc_end && mode_q == MODE_COUNT) begin
        beeps_left <= beeps_left - COUNT_W'(1);
      end
    end
  end

  assign restart     = (state_nx == S_ON) && (state != S_ON);
  assign beep_active = (state == S_ON);
  assign busy        = (state != S_IDLE);
  assign buzz_out    = beep_active & tone;

  tone_gen #(
    .TONE_HALF(TONE_HALF)
  ) u_tone (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .en     (beep_active),
    .tone   (tone)
  );

endmodule
